// File: rtl/dram_pkg.sv
// Shared constants for the CPU-word to DRAM-line port: FSM encoding and lane mapping.
// Lane 0 is the most significant 32-bit word of a line (big-endian lane order).
package dram_pkg;

  localparam int LANE_W = 2;
  localparam int LANES  = 4;

  localparam logic [2:0] ST_CALIB    = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_WR_PULSE = 3'd2;
  localparam logic [2:0] ST_WR_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_PULSE = 3'd4;
  localparam logic [2:0] ST_RD_WAIT  = 3'd5;
  localparam logic [2:0] ST_ACK      = 3'd6;

  // Physical word slot inside a line for a CPU lane (lane 0 sits in the top word).
  function automatic logic [LANE_W-1:0] lane_slot(input logic [LANE_W-1:0] lane);
    return LANE_W'(LANES - 1) - lane;
  endfunction

endpackage

// File: rtl/dram_word_port_if.sv
// DRAM user-interface side of the word port: command strobes, line data/mask and status.
interface dram_word_port_if #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
);
  logic                      d_rd_en;
  logic                      d_wr_en;
  logic [APP_ADDR_WIDTH-1:0] d_addr;
  logic [APP_DATA_WIDTH-1:0] d_data;
  logic [APP_MASK_WIDTH-1:0] d_mask;
  logic [APP_DATA_WIDTH-1:0] d_rdata;
  logic                      d_rdata_valid;
  logic                      d_ready;
  logic                      d_wdf_ready;
  logic                      d_calib_done;

  modport master (
    output d_rd_en, d_wr_en, d_addr, d_data, d_mask,
    input  d_rdata, d_rdata_valid, d_ready, d_wdf_ready, d_calib_done
  );

  modport slave (
    input  d_rd_en, d_wr_en, d_addr, d_data, d_mask,
    output d_rdata, d_rdata_valid, d_ready, d_wdf_ready, d_calib_done
  );
endinterface

// File: rtl/dram_line_buf.sv
// Single-line read buffer: holds the last DRAM read line with its tag, answers lane
// lookups and merges CPU write bytes into the held line on a tag hit.
module dram_line_buf
  import dram_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  input  logic [LANE_W-1:0] i_lookup_lane,
  input  logic              i_merge_en,
  input  logic [31:0]       i_merge_data,
  input  logic [3:0]        i_merge_be,
  input  logic              i_fill_en,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [DATA_W-1:0] i_fill_line,
  output logic              o_hit,
  output logic [31:0]       o_word
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] line_q, line_d;

  assign o_hit  = valid_q && (tag_q == i_lookup_addr);
  assign o_word = line_q[32*lane_slot(i_lookup_lane) +: 32];

  // Fill (RD_WAIT) and merge (IDLE accept) come from different FSM states, never together.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    line_d  = line_q;
    if (i_fill_en) begin
      valid_d = 1'b1;
      tag_d   = i_fill_addr;
      line_d  = i_fill_line;
    end else if (i_merge_en && o_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_merge_be[b]) begin
          line_d[32*lane_slot(i_lookup_lane) + 8*b +: 8] = i_merge_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/dram_word_port.sv
// 32-bit CPU word port onto a 128-bit DRAM user interface. Optional single-line read
// buffer is built when DRAM_LINE_BUF_EN is defined.
module dram_word_port
  import dram_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state,
  dram_word_port_if.master dram
);

  // Handshake: i_req is taken in any cycle with o_busy=0; o_ack pulses once per taken
  // request. d_rd_en/d_wr_en are one-cycle strobes; a write completes on
  // d_ready&d_wdf_ready, a read on d_rdata_valid, both only in their wait states.
  logic [2:0]                state_q, state_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [APP_ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
  logic [APP_DATA_WIDTH-1:0] d_data_q, d_data_d;
  logic [APP_MASK_WIDTH-1:0] d_mask_q, d_mask_d;
  logic [31:0]               o_rdata_q, o_rdata_d;

  logic [APP_ADDR_WIDTH-1:0] req_line_addr;
  logic [LANE_W-1:0]         req_lane;
  logic [APP_MASK_WIDTH-1:0] req_mask;
  logic [31:0]               rd_word;
  logic                      buf_hit;
  logic [31:0]               buf_word;
  logic                      unused_addr_bits;

  assign req_line_addr    = {i_addr[APP_ADDR_WIDTH:4], 3'b000};
  assign req_lane         = i_addr[3:2];
  assign rd_word          = dram.d_rdata[32*lane_slot(lane_q) +: 32];
  assign unused_addr_bits = ^{i_addr[31:APP_ADDR_WIDTH+1], i_addr[1:0]};

  always_comb begin
    req_mask = '1;
    req_mask[4*lane_slot(req_lane) +: 4] = ~i_be;
  end

`ifdef DRAM_LINE_BUF_EN
  dram_line_buf #(
    .ADDR_W (APP_ADDR_WIDTH),
    .DATA_W (APP_DATA_WIDTH)
  ) u_line_buf (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_lookup_addr (req_line_addr),
    .i_lookup_lane (req_lane),
    .i_merge_en    ((state_q == ST_IDLE) && i_req && i_we),
    .i_merge_data  (i_wdata),
    .i_merge_be    (i_be),
    .i_fill_en     ((state_q == ST_RD_WAIT) && dram.d_rdata_valid),
    .i_fill_addr   (d_addr_q),
    .i_fill_line   (dram.d_rdata),
    .o_hit         (buf_hit),
    .o_word        (buf_word)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    d_addr_d  = d_addr_q;
    d_data_d  = d_data_q;
    d_mask_d  = d_mask_q;
    o_rdata_d = o_rdata_q;
    case (state_q)
      ST_CALIB:    if (dram.d_calib_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (i_req) begin
          lane_d   = req_lane;
          d_addr_d = req_line_addr;
          d_data_d = APP_DATA_WIDTH'({LANES{i_wdata}});
          d_mask_d = req_mask;
          if (i_we) begin
            state_d = ST_WR_PULSE;
          end else if (buf_hit) begin
            o_rdata_d = buf_word;
            state_d   = ST_ACK;
          end else begin
            state_d = ST_RD_PULSE;
          end
        end
      end
      ST_WR_PULSE: state_d = ST_WR_WAIT;
      ST_WR_WAIT:  if (dram.d_ready && dram.d_wdf_ready) state_d = ST_ACK;
      ST_RD_PULSE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (dram.d_rdata_valid) begin
          o_rdata_d = rd_word;
          state_d   = ST_ACK;
        end
      end
      ST_ACK:      state_d = ST_IDLE;
      default:     state_d = ST_CALIB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_CALIB;
      lane_q    <= '0;
      d_addr_q  <= '0;
      d_data_q  <= '0;
      d_mask_q  <= '0;
      o_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      d_addr_q  <= d_addr_d;
      d_data_q  <= d_data_d;
      d_mask_q  <= d_mask_d;
      o_rdata_q <= o_rdata_d;
    end
  end

  assign dram.d_wr_en = (state_q == ST_WR_PULSE);
  assign dram.d_rd_en = (state_q == ST_RD_PULSE);
  assign dram.d_addr  = d_addr_q;
  assign dram.d_data  = d_data_q;
  assign dram.d_mask  = d_mask_q;
  assign o_rdata      = o_rdata_q;
  assign o_ack        = (state_q == ST_ACK);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_dram_word_port.sv
// Self-checking bench for dram_word_port: a DRAM responder driven from tasks and a
// scoreboard of expected read words popped on each read ack.
module tb_dram_word_port;
  import dram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_be;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_busy;
  logic [2:0]  o_dbg_state;

  dram_word_port_if #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)) dram_if ();

  dram_word_port #(.APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_be        (i_be),
    .o_rdata     (o_rdata),
    .o_ack       (o_ack),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state),
    .dram        (dram_if)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [27:0]  last_addr;
  logic [15:0]  last_mask;
  logic [127:0] last_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane 0 is the top 32-bit word of the line.
  function automatic logic [15:0] model_mask(input logic [31:0] addr, input logic [3:0] be);
    logic [15:0] m;
    int slot;
    m = 16'hFFFF;
    slot = 3 - int'(addr[3:2]);
    m[slot*4 +: 4] = ~be;
    return m;
  endfunction

  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] lane);
    int slot;
    slot = 3 - int'(lane);
    return line[slot*32 +: 32];
  endfunction

  function automatic logic [27:0] model_addr(input logic [31:0] addr);
    return {addr[28:4], 3'b000};
  endfunction

  // ---------------- driver ----------------
  // One CPU access with a DRAM responder: read data returned rd_delay cycles after
  // d_rd_en; d_wdf_ready held low for wdf_hold cycles of WR_WAIT. Latency counts the
  // request cycle as cycle 1; exp_lat < 0 skips the latency check.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [127:0] line, input int rd_delay,
                           input int wdf_hold, input int exp_wr, input int exp_rd, input int exp_lat);
    int   wr_cnt, rd_cnt, ack_cnt, ack_k, rd_k, busy_low;
    logic both;
    wr_cnt = 0; rd_cnt = 0; ack_cnt = 0; ack_k = 0; rd_k = 0; busy_low = 0; both = 1'b0;
    check("idle_before_req", 128'(o_busy), 128'(0));
    if (!we) exp_q.push_back(line_word(line, addr[3:2]));
    if (wdf_hold > 0) dram_if.d_wdf_ready = 1'b0;
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_be = be;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (dram_if.d_wr_en && dram_if.d_rd_en) both = 1'b1;
      if (dram_if.d_wr_en) begin
        wr_cnt++;
        last_addr = dram_if.d_addr; last_mask = dram_if.d_mask; last_data = dram_if.d_data;
      end
      if (dram_if.d_rd_en) begin
        rd_cnt++; rd_k = k; last_addr = dram_if.d_addr;
      end
      if (o_ack) begin
        ack_cnt++;
        if (ack_cnt == 1) ack_k = k;
        if (!we && exp_q.size() > 0) check("rdata", 128'(o_rdata), 128'(exp_q.pop_front()));
      end else if (ack_cnt == 0 && !o_busy) begin
        busy_low++;
      end
      i_req = 1'b0;
      dram_if.d_rdata_valid = (rd_k > 0) && (k == rd_k + rd_delay);
      if (dram_if.d_rdata_valid) dram_if.d_rdata = line;
      if (k >= wdf_hold + 2) dram_if.d_wdf_ready = 1'b1;
      if (ack_cnt > 0 && k >= ack_k + 1) break;
    end
    dram_if.d_rdata_valid = 1'b0;
    dram_if.d_wdf_ready   = 1'b1;
    check("wr_pulses", 128'(wr_cnt), 128'(exp_wr));
    check("rd_pulses", 128'(rd_cnt), 128'(exp_rd));
    check("ack_count", 128'(ack_cnt), 128'(1));
    check("rd_wr_exclusive", 128'(both), 128'(0));
    check("busy_until_ack", 128'(busy_low), 128'(0));
    if (we && wr_cnt == 1) begin
      check("wr_d_addr", 128'(last_addr), 128'(model_addr(addr)));
      check("wr_d_mask", 128'(last_mask), 128'(model_mask(addr, be)));
      check("wr_d_data", last_data, {4{wdata}});
    end
    if (!we && rd_cnt == 1) begin
      check("rd_d_addr", 128'(last_addr), 128'(model_addr(addr)));
      check("rd_ack_after_valid", 128'(ack_k), 128'(rd_k + rd_delay + 1));
    end
    if (exp_lat >= 0) check("latency", 128'(ack_k + 1), 128'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] line;
    logic [31:0]  addr, wd;
    logic [3:0]   be;
    int           hold, dly, cnt_rd, cnt_wr, cnt_busy_low, acks, seen;

    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_be = '0;
    dram_if.d_rdata = '0; dram_if.d_rdata_valid = 1'b0; dram_if.d_ready = 1'b1;
    dram_if.d_wdf_ready = 1'b1; dram_if.d_calib_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", 128'(o_dbg_state), 128'(ST_CALIB));
    check("rst_busy", 128'(o_busy), 128'(1));
    check("rst_ack", 128'(o_ack), 128'(0));
    check("rst_rd_en", 128'(dram_if.d_rd_en), 128'(0));
    check("rst_wr_en", 128'(dram_if.d_wr_en), 128'(0));
    check("rst_rdata", 128'(o_rdata), 128'(0));
    check("rst_d_addr", 128'(dram_if.d_addr), 128'(0));
    check("rst_d_data", dram_if.d_data, 128'(0));
    check("rst_d_mask", 128'(dram_if.d_mask), 128'(0));
    i_rst = 1'b0;

    // Calibration pending: requests ignored for 50 cycles
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h24; i_wdata = 32'h1; i_be = 4'hF;
    cnt_rd = 0; cnt_wr = 0; cnt_busy_low = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dram_if.d_rd_en) cnt_rd++;
      if (dram_if.d_wr_en) cnt_wr++;
      if (!o_busy) cnt_busy_low++;
    end
    check("calib_rd_pulses", 128'(cnt_rd), 128'(0));
    check("calib_wr_pulses", 128'(cnt_wr), 128'(0));
    check("calib_busy", 128'(cnt_busy_low), 128'(0));
    check("calib_state", 128'(o_dbg_state), 128'(ST_CALIB));
    i_req = 1'b0;
    dram_if.d_calib_done = 1'b1;
    @(negedge clk);
    check("calib_to_idle", 128'(o_dbg_state), 128'(ST_IDLE));
    check("idle_not_busy", 128'(o_busy), 128'(0));

    // Write 0x24, two low bytes
    do_access(1'b1, 32'h0000_0024, 32'hDEADBEEF, 4'b0011, 128'h0, 0, 0, 1, 0, 4);
    check("w24_d_addr", 128'(last_addr), 128'(28'h10));
    check("w24_d_mask", 128'(last_mask), 128'(16'hFCFF));

    // Read 0x38, lane 2 returned 10 cycles after d_rd_en
    line = {32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 32'h4444_4444};
    do_access(1'b0, 32'h0000_0038, 32'h0, 4'h0, line, 10, 0, 0, 1, -1);
    check("r38_rdata", 128'(o_rdata), 128'(32'h1234_5678));

    // Stray read data in IDLE is ignored
    acks = 0;
    dram_if.d_rdata = {4{32'h5555_AAAA}};
    for (int k = 0; k < 3; k++) begin
      dram_if.d_rdata_valid = 1'b1;
      @(negedge clk);
      if (o_ack) acks++;
    end
    dram_if.d_rdata_valid = 1'b0;
    check("idle_stray_ack", 128'(acks), 128'(0));
    check("idle_stray_rdata", 128'(o_rdata), 128'(32'h1234_5678));

    // Zero byte enables still write (nothing) and ack
    do_access(1'b1, 32'h0000_0108, 32'h0BAD_0BAD, 4'h0, 128'h0, 0, 0, 1, 0, 4);
    check("be0_mask", 128'(last_mask), 128'(16'hFFFF));
    check("rdata_hold", 128'(o_rdata), 128'(32'h1234_5678));

    // Write-data path stalled 20 cycles in WR_WAIT
    do_access(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 128'h0, 0, 20, 1, 0, 24);

    // Random mix; reads use distinct lines
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        addr = $urandom; wd = $urandom; be = 4'($urandom_range(0, 15)); hold = $urandom_range(0, 3);
        do_access(1'b1, addr, wd, be, 128'h0, 0, hold, 1, 0, 4 + hold);
      end else begin
        addr = 32'h1000 + 32'(i * 16) + 32'($urandom_range(0, 3) * 4);
        line = {$urandom, $urandom, $urandom, $urandom};
        dly  = $urandom_range(1, 6);
        do_access(1'b0, addr, 32'h0, 4'h0, line, dly, 0, 0, 1, -1);
      end
    end

    // Reset lands in RD_WAIT, then late read data arrives
    i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_2000;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      i_req = 1'b0;
      if (dram_if.d_rd_en) begin
        seen = 1;
        break;
      end
    end
    check("rst_rd_issued", 128'(seen), 128'(1));
    repeat (3) @(negedge clk);
    check("rst_in_rd_wait", 128'(o_dbg_state), 128'(ST_RD_WAIT));
    dram_if.d_calib_done = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    acks = 0;
    dram_if.d_rdata = {4{32'h7777_7777}};
    for (int k = 0; k < 10; k++) begin
      dram_if.d_rdata_valid = (k < 3);
      @(negedge clk);
      if (o_ack) acks++;
    end
    dram_if.d_rdata_valid = 1'b0;
    check("rst_mid_rd_no_ack", 128'(acks), 128'(0));
    check("rst_mid_rd_state", 128'(o_dbg_state), 128'(ST_CALIB));
    check("rst_mid_rd_busy", 128'(o_busy), 128'(1));
    check("rst_mid_rd_rdata", 128'(o_rdata), 128'(0));
    dram_if.d_calib_done = 1'b1;
    @(negedge clk);
    check("recal_idle", 128'(o_dbg_state), 128'(ST_IDLE));

`ifdef DRAM_LINE_BUF_EN
    // Line buffer: fill on read 0x40, merge write 0x44, hit read 0x44 without DRAM
    line = {32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0D0D_0D0D};
    do_access(1'b0, 32'h0000_0040, 32'h0, 4'h0, line, 4, 0, 0, 1, -1);
    do_access(1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'hF, 128'h0, 0, 0, 1, 0, 4);
    line = {32'h0A0A_0A0A, 32'hA5A5_A5A5, 32'h0C0C_0C0C, 32'h0D0D_0D0D};
    do_access(1'b0, 32'h0000_0044, 32'h0, 4'h0, line, 4, 0, 0, 0, 2);
    check("buf_hit_rdata", 128'(o_rdata), 128'(32'hA5A5_A5A5));
`endif

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_word_port.md
DRAM_WORD_PORT -- requirements
Module: dram_word_port

Interface
REQ-001 SHALL have parameters: APP_ADDR_WIDTH, default 28, DRAM-side line address width; APP_DATA_WIDTH, default 128, line width; APP_MASK_WIDTH, default 16, byte-mask width.
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_req  in  1  CPU access request, sampled only when o_busy=0
i_we  in  1  1=write, 0=read, qualified by i_req
i_addr  in  32  CPU byte address
i_wdata  in  32  write word
i_be  in  4  byte enables, active-high
o_rdata  out  32  read word, valid while o_ack=1
o_ack  out  1  one-cycle completion pulse for reads and writes
o_busy  out  1  request cannot be accepted
d_rd_en  out  1  one-cycle read pulse to the downstream MIG user-interface stage
d_wr_en  out  1  one-cycle write pulse to the same stage
d_addr  out  APP_ADDR_WIDTH  line address
d_data  out  APP_DATA_WIDTH  write line
d_mask  out  APP_MASK_WIDTH  byte mask, 1=byte NOT written
d_rdata  in  APP_DATA_WIDTH  read line
d_rdata_valid  in  1  read line valid
d_ready  in  1  command path ready
d_wdf_ready  in  1  write-data path ready
d_calib_done  in  1  DRAM calibration complete

Function
REQ-003 SHALL use FSM states CALIB, IDLE, WR_PULSE, WR_WAIT, RD_PULSE, RD_WAIT, ACK.
REQ-004 SHALL hold o_busy=1 in every state except IDLE.
REQ-005 SHALL leave CALIB for IDLE on the first cycle with d_calib_done=1, and ignore i_req while in CALIB.
REQ-006 SHALL latch i_addr, i_we, i_wdata and i_be when i_req=1 in IDLE, then go to WR_PULSE if i_we=1, else to RD_PULSE.
REQ-007 SHALL compute d_addr as {i_addr[APP_ADDR_WIDTH:4], 3'b000}, truncated to APP_ADDR_WIDTH bits.
REQ-008 SHALL replicate i_wdata into all four 32-bit lanes of d_data.
REQ-009 SHALL set d_mask to all 1s except the 4-bit group for lane i_addr[3:2], which SHALL be ~i_be.
REQ-010 SHALL drive d_wr_en=1 for exactly one cycle in WR_PULSE, then go to WR_WAIT.
REQ-011 SHALL remain in WR_WAIT until a cycle with d_ready=1 and d_wdf_ready=1, then go to ACK.
REQ-012 SHALL drive d_rd_en=1 for exactly one cycle in RD_PULSE, then go to RD_WAIT.
REQ-013 SHALL, on d_rdata_valid=1 in RD_WAIT, register lane i_addr[3:2] of d_rdata into o_rdata and go to ACK.
REQ-014 SHALL assert o_ack for one cycle in ACK, then return to IDLE; o_rdata SHALL hold its value until the next read completes.
REQ-015 SHALL give minimum latency, i_req to o_ack, of 4 cycles for writes and 4 + DRAM read latency for reads.
REQ-016 SHALL ignore d_rdata_valid outside RD_WAIT.
REQ-017 SHALL treat i_be=0 as a normal write with all mask bits 1, and still pulse o_ack.
REQ-018 SHALL never assert d_rd_en and d_wr_en in the same cycle.

Reset
REQ-019 SHALL, on i_rst=1, enter CALIB with o_busy=1, o_ack=0, d_rd_en=0, d_wr_en=0, o_rdata=0, d_addr=0, d_data=0 and d_mask=0, abandoning any access in flight without an ack.
REQ-020 SHALL, if reset lands mid-read, discard any later d_rdata_valid for that read (REQ-016).

Configuration
REQ-021 SHALL, with DRAM_LINE_BUF_EN defined, keep the last read line plus its line address and a valid bit.
REQ-022 SHALL, with DRAM_LINE_BUF_EN defined, serve a read hit in IDLE from the buffer via ACK with no DRAM access (latency 2).
REQ-023 SHALL, with DRAM_LINE_BUF_EN defined, merge enabled bytes into the buffer on a write hit while still writing to DRAM.
REQ-024 SHALL, with DRAM_LINE_BUF_EN defined, clear the valid bit on reset.
REQ-025 SHALL, with DRAM_LINE_BUF_EN undefined, send every read to DRAM and contain no buffer storage.

Structure
REQ-026 SHALL place the FSM state encoding, lane-select width and CALIB/IDLE constants in shared package dram_pkg.
REQ-027 SHALL implement the line buffer as sub-module dram_line_buf (storage, tag compare, byte merge), instantiated only with DRAM_LINE_BUF_EN.

Verification
REQ-028 SHALL cover: d_calib_done=0 for 50 cycles with i_req=1 -> no d_rd_en/d_wr_en pulses and o_busy=1 throughout.
REQ-029 SHALL cover: write addr 0x0000_0024, wdata 0xDEADBEEF, be 4'b0011 -> d_addr=0x10, d_mask=16'hFCFF, one d_wr_en pulse, o_ack 4 cycles after i_req when ready.
REQ-030 SHALL cover: read addr 0x0000_0038 with d_rdata lane 2=0x12345678 after 10 cycles -> o_rdata=0x12345678 with one o_ack.
REQ-031 SHALL cover: d_wdf_ready held 0 for 20 cycles in WR_WAIT -> o_busy stays 1, no second d_wr_en, o_ack after ready returns.
REQ-032 SHALL cover: i_rst pulsed in RD_WAIT, then stray d_rdata_valid -> no o_ack, FSM in CALIB.
REQ-033 SHALL cover, with DRAM_LINE_BUF_EN: read 0x40, write 0x44 with 0xA5A5A5A5, read 0x44 -> last read returns 0xA5A5A5A5 with no d_rd_en.
